fc_outneuron_writeback: RTL

- Downstream stage of the FC control/MAC datapath.
- Captures each finished dot-product sum from the PO accumulators and adds the per-neuron bias.
- Rescales the result by arithmetic shift, then applies ReLU and saturation to DATA_WIDTH_FC.
- Writes the result to the out-neuron M9K at a sequential address and asserts done after OUTNEURON/PO writes.

---
 rtl/fc_outneuron_writeback_pkg.sv | 20 ++
 rtl/fc_bias_relu_sat.sv | 41 ++++
 rtl/fc_outneuron_writeback.sv | 118 +++++++++++
 3 files changed

// File: rtl/fc_outneuron_writeback_pkg.sv
// Shared FC layer constants and FSM encodings for the out-neuron writeback stage.
// Layer-geometry values are the defaults of the writeback top parameters.
package fc_outneuron_writeback_pkg;

  localparam int OUTNEURON               = 10;
  localparam int INNEURON                = 84;
  localparam int PO                      = 1;
  localparam int DATA_WIDTH_FC           = 16;
  localparam int ACCUM_DATA_WIDTH_FC     = 32;
  localparam int FC_OUTNEURON_ADDR_WIDTH = 4;
  localparam int FC_FRAC_SHIFT           = 8;
  localparam int FC_RELU_EN              = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/fc_bias_relu_sat.sv
// Per-lane combinational arithmetic: bias add, and from the registered sum,
// arithmetic rescale, optional ReLU and saturation to the neuron word width.
module fc_bias_relu_sat #(
  parameter int ACCW  = 32,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int RELU  = 1
) (
  input  logic [ACCW-1:0]      acc,
  input  logic [DW-1:0]        bias,
  input  logic signed [ACCW:0] sum_q,
  output logic signed [ACCW:0] sum,
  output logic [DW-1:0]        res
);

  localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_MIN = {{(ACCW+2-DW){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACCW:0] acc_x, bias_x, shifted;

  // Bias is stored in the output number format, so it is aligned to the
  // accumulator's fraction point before the add.
  always_comb begin
    acc_x  = {acc[ACCW-1], acc};
    bias_x = {{(ACCW+1-DW){bias[DW-1]}}, bias} << FRAC;
    sum    = acc_x + bias_x;
  end

  always_comb begin
    shifted = sum_q >>> FRAC;
    if (RELU != 0 && shifted[ACCW])
      res = '0;
    else if (shifted > SAT_MAX)
      res = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < SAT_MIN)
      res = {1'b1, {(DW-1){1'b0}}};
    else
      res = shifted[DW-1:0];
  end

endmodule

// File: rtl/fc_outneuron_writeback.sv
// FC out-neuron writeback: captures finished PO sums, adds bias, rescales,
// ReLU/saturates and writes sequential out-neuron RAM words; flags layer done.
module fc_outneuron_writeback
  import fc_outneuron_writeback_pkg::*;
#(
  parameter int OUTNEURON               = fc_outneuron_writeback_pkg::OUTNEURON,
  parameter int PO                      = fc_outneuron_writeback_pkg::PO,
  parameter int DATA_WIDTH_FC           = fc_outneuron_writeback_pkg::DATA_WIDTH_FC,
  parameter int ACCUM_DATA_WIDTH_FC     = fc_outneuron_writeback_pkg::ACCUM_DATA_WIDTH_FC,
  parameter int FRAC_SHIFT              = FC_FRAC_SHIFT,
  parameter int RELU_EN                 = FC_RELU_EN,
  parameter int FC_OUTNEURON_ADDR_WIDTH = fc_outneuron_writeback_pkg::FC_OUTNEURON_ADDR_WIDTH
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 accum_sload,
  input  logic [ACCUM_DATA_WIDTH_FC*PO-1:0]    accum_result_all,
  output logic                                 bias_rden,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]   bias_addr,
  input  logic [DATA_WIDTH_FC*PO-1:0]          bias_q_all,
  output logic                                 out_neuron_wren,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]   out_neuron_addr,
  output logic [DATA_WIDTH_FC*PO-1:0]          out_neuron_data_all,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ACCW   = ACCUM_DATA_WIDTH_FC;
  localparam int DW     = DATA_WIDTH_FC;
  localparam int AW     = FC_OUTNEURON_ADDR_WIDTH;
  localparam int STAGES = 3;
  localparam logic [AW-1:0] LAST_IDX = AW'(OUTNEURON/PO - 1);

  logic [2:0]              state;
  logic [AW-1:0]           idx;
  logic [STAGES:0]         vld_pipe;
  logic [PO-1:0][ACCW-1:0] acc_s0;
  logic [PO-1:0][ACCW:0]   sum_s1, sum_c;
  logic [PO-1:0][DW-1:0]   res_s2, res_c, data_q;
  logic [AW-1:0]           addr_s1, addr_s2;
  logic                    capture;

  assign capture             = (state == ST_RUN) && enable && accum_sload;
  assign busy                = |vld_pipe[STAGES-1:0];
  assign done                = (state == ST_DONE);
  assign bias_rden           = vld_pipe[0];
  assign out_neuron_wren     = vld_pipe[STAGES];
  assign out_neuron_data_all = data_q;

  for (genvar p = 0; p < PO; p++) begin : g_lane
    fc_bias_relu_sat #(
      .ACCW (ACCW),
      .DW   (DW),
      .FRAC (FRAC_SHIFT),
      .RELU (RELU_EN)
    ) u_lane (
      .acc   (acc_s0[p]),
      .bias  (bias_q_all[p*DW +: DW]),
      .sum_q (sum_s1[p]),
      .sum   (sum_c[p]),
      .res   (res_c[p])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (enable) state <= ST_ARMED;
        // First reload marks the start of neuron 0; there is no sum behind it yet.
        ST_ARMED: if (enable && accum_sload) state <= ST_RUN;
        ST_RUN: if (capture) begin
          if (idx == LAST_IDX) state <= ST_DRAIN;
          else                 idx   <= idx + 1'b1;
        end
        ST_DRAIN: if (!busy) state <= ST_DONE;
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe        <= '0;
      acc_s0          <= '0;
      sum_s1          <= '0;
      res_s2          <= '0;
      data_q          <= '0;
      bias_addr       <= '0;
      addr_s1         <= '0;
      addr_s2         <= '0;
      out_neuron_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], capture};
      if (capture) begin
        acc_s0    <= accum_result_all;
        bias_addr <= idx;
      end
      if (vld_pipe[0]) begin
        sum_s1  <= sum_c;
        addr_s1 <= bias_addr;
      end
      if (vld_pipe[1]) begin
        res_s2  <= res_c;
        addr_s2 <= addr_s1;
      end
      if (vld_pipe[2]) begin
        data_q          <= res_s2;
        out_neuron_addr <= addr_s2;
      end
    end
  end

endmodule
